// File: rtl/gate3_truth_table_sequencer_pkg.sv
// Shared types and constants for the 3-input gate truth-table sequencer.
package gate3_seq_pkg;

    // Sequencer FSM states; also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_PATTERNS = 8;

    // Expected-F tables: bit i is F for {a,b,c} == i.
    localparam logic [7:0] TT_OR3   = 8'hFE;
    localparam logic [7:0] TT_AND3  = 8'h80;
    localparam logic [7:0] TT_XOR3  = 8'h96;
    localparam logic [7:0] TT_NOR3  = 8'h01;
    localparam logic [7:0] TT_NAND3 = 8'h7F;

    // True when the sampled gate output disagrees with the table entry.
    function automatic logic is_mismatch(input logic [7:0] tt,
                                         input logic [2:0] idx,
                                         input logic       f);
        return f ^ tt[idx];
    endfunction

endpackage

// File: rtl/gate3_truth_table_sequencer_if.sv
// Signal bundle between the sequencer and the gate/test environment.
//
// Handshake: start is a level request with no ready. It is accepted on any
// rising edge where the sequencer is not in RUN (busy=0); while busy=1 it is
// ignored. Results (pass, err_count, first_fail_idx, fail_mask) are valid
// while done=1 and stay valid until the next accepted start.
interface gate3_truth_table_sequencer_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       f_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_idx;
    logic [7:0] fail_mask;

    // Sequencer side: drives stimulus and results.
    modport master (
        input  start, f_in,
        output a, b, c, busy, done, pass, err_count, first_fail_idx, fail_mask
    );

    // Environment side: requests runs and returns the gate output.
    modport slave (
        output start, f_in,
        input  a, b, c, busy, done, pass, err_count, first_fail_idx, fail_mask
    );
endinterface

// File: rtl/gate3_truth_table_sequencer_dwell_timer.sv
// Per-pattern dwell counter: counts 0..DWELL_CYCLES-1 and flags the last cycle.
module dwell_timer #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int W = $clog2(DWELL_CYCLES + 1);
    localparam logic [W-1:0] TC_VAL = W'(DWELL_CYCLES - 1);

    logic [W-1:0] count;

    // Load (clear) wins over increment so a new pattern always starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/gate3_truth_table_sequencer.sv
// Clocked stimulus sequencer and result checker for a 3-input combinational
// gate: walks {a,b,c} through 000..111, samples F on the last dwell cycle of
// each pattern and accumulates mismatches against EXPECT_TT.
module gate3_truth_table_sequencer
    import gate3_seq_pkg::*;
#(
    parameter int         DWELL_CYCLES = 4,
    parameter logic [7:0] EXPECT_TT    = 8'hFE
) (
    input  logic                                clk,
    input  logic                                rst,
    gate3_truth_table_sequencer_if.master       bus,
    output state_t                              state_dbg
);
    localparam logic [2:0] LAST_IDX = 3'(NUM_PATTERNS - 1);

    state_t     state_q, state_n;
    logic [2:0] idx_q, idx_n;
    logic [2:0] abc_q, abc_n;
    logic       busy_q, busy_n;
    logic       done_q, done_n;
    logic       pass_q, pass_n;
    logic [3:0] err_q, err_n;
    logic [2:0] ffi_q, ffi_n;
    logic [7:0] mask_q, mask_n;

    logic timer_load;
    logic timer_en;
    logic timer_tc;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    // State, pattern index and result registers; every output comes from here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffi_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            abc_q   <= abc_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            pass_q  <= pass_n;
            err_q   <= err_n;
            ffi_q   <= ffi_n;
            mask_q  <= mask_n;
        end
    end

    // Next-state and next-output logic; a start from IDLE or DONE clears all results.
    always_comb begin
        state_n    = state_q;
        idx_n      = idx_q;
        abc_n      = abc_q;
        busy_n     = busy_q;
        done_n     = done_q;
        pass_n     = pass_q;
        err_n      = err_q;
        ffi_n      = ffi_q;
        mask_n     = mask_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n    = RUN;
                    idx_n      = '0;
                    abc_n      = '0;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    err_n      = '0;
                    ffi_n      = '0;
                    mask_n     = '0;
                    timer_load = 1'b1;
                end
            end
            RUN: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    timer_load = 1'b1;
                    if (is_mismatch(EXPECT_TT, idx_q, bus.f_in)) begin
                        mask_n[idx_q] = 1'b1;
                        err_n         = err_q + 4'd1;
                        if (err_q == 4'd0) begin
                            ffi_n = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_n = DONE;
                        abc_n   = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 4'd0);
                    end else begin
                        idx_n = idx_q + 3'd1;
                        abc_n = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.a              = abc_q[2];
    assign bus.b              = abc_q[1];
    assign bus.c              = abc_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.fail_mask      = mask_q;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_gate3_truth_table_sequencer.sv
// Bench for gate3_truth_table_sequencer: two instances (dwell 4 / OR3 and
// dwell 1 / AND3) driven by a table-defined gate model.
module tb_gate3_truth_table_sequencer;
    import gate3_seq_pkg::*;

    localparam int DW_A = 4;
    localparam int DW_B = 1;

    typedef struct packed {
        logic [2:0] abc;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] err;
        logic [2:0] ffi;
        logic [7:0] mask;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gate3_truth_table_sequencer_if if_a ();
    gate3_truth_table_sequencer_if if_b ();

    logic [7:0] gate_tt_a;
    logic [7:0] gate_tt_b;
    state_t     st_a;
    state_t     st_b;

    // Gate under test: arbitrary truth table looked up from the stimulus.
    assign if_a.f_in = gate_tt_a[{if_a.a, if_a.b, if_a.c}];
    assign if_b.f_in = gate_tt_b[{if_b.a, if_b.b, if_b.c}];

    gate3_truth_table_sequencer #(
        .DWELL_CYCLES(DW_A),
        .EXPECT_TT   (TT_OR3)
    ) dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_a.master),
        .state_dbg(st_a)
    );

    gate3_truth_table_sequencer #(
        .DWELL_CYCLES(DW_B),
        .EXPECT_TT   (TT_AND3)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_b.master),
        .state_dbg(st_b)
    );

    // ---------------- scoreboard ----------------
    logic [2:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: result of checking a gate with table g against expected table e.
    task automatic model(input logic [7:0] g, input logic [7:0] e,
                         output logic [7:0] m, output logic [3:0] n,
                         output logic [2:0] f, output logic p);
        m = g ^ e;
        n = 4'($countones(m));
        f = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) f = 3'(i);
        end
        p = (m == 8'h00);
    endtask

    // ---------------- driver tasks ----------------
    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel != 0) begin
            o = '{abc: {if_b.a, if_b.b, if_b.c}, busy: if_b.busy, done: if_b.done,
                  pass: if_b.pass, err: if_b.err_count, ffi: if_b.first_fail_idx,
                  mask: if_b.fail_mask};
        end else begin
            o = '{abc: {if_a.a, if_a.b, if_a.c}, busy: if_a.busy, done: if_a.done,
                  pass: if_a.pass, err: if_a.err_count, ffi: if_a.first_fail_idx,
                  mask: if_a.fail_mask};
        end
        return o;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) if_b.start = v;
        else          if_a.start = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full run on instance sel, called at a negedge with the instance idle or done.
    // mid_j >= 0 pulses start during RUN after edge mid_j; hold keeps start high throughout.
    task automatic run_seq(input int sel, input logic [7:0] gate_tt, input int mid_j, input bit hold);
        int         d;
        logic [7:0] exp_tt;
        obs_t       o;
        logic [7:0] m_mask;
        logic [3:0] m_err;
        logic [2:0] m_ffi;
        logic       m_pass;
        d      = (sel != 0) ? DW_B : DW_A;
        exp_tt = (sel != 0) ? TT_AND3 : TT_OR3;
        if (sel != 0) gate_tt_b = gate_tt;
        else          gate_tt_a = gate_tt;
        model(gate_tt, exp_tt, m_mask, m_err, m_ffi, m_pass);
        exp_q.delete();
        for (int j = 0; j < 8 * d; j++) exp_q.push_back(3'(j / d));

        set_start(sel, 1'b1);
        @(negedge clk);
        for (int j = 0; j < 8 * d; j++) begin
            set_start(sel, logic'(hold || (j == mid_j)));
            o = sample(sel);
            check("abc_step", 32'(o.abc), 32'(exp_q.pop_front()));
            check("busy_run", 32'(o.busy), 32'd1);
            check("done_run", 32'(o.done), 32'd0);
            if (j == 0) begin
                check("results_cleared", 32'({o.pass, o.err, o.ffi, o.mask}), 32'd0);
            end
            @(negedge clk);
        end
        if (!hold) set_start(sel, 1'b0);
        o = sample(sel);
        check("done_end", 32'(o.done), 32'd1);
        check("busy_end", 32'(o.busy), 32'd0);
        check("abc_end", 32'(o.abc), 32'd0);
        check("pass", 32'(o.pass), 32'(m_pass));
        check("err_count", 32'(o.err), 32'(m_err));
        check("first_fail_idx", 32'(o.ffi), 32'(m_ffi));
        check("fail_mask", 32'(o.mask), 32'(m_mask));
        check("state_done", 32'((sel != 0) ? st_b : st_a), 32'(DONE));
        if (hold) begin
            @(negedge clk);
            o = sample(sel);
            check("hold_restart_busy", 32'(o.busy), 32'd1);
            check("hold_restart_done", 32'(o.done), 32'd0);
            check("hold_restart_clear", 32'({o.abc, o.pass, o.err, o.ffi, o.mask}), 32'd0);
            set_start(sel, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        obs_t       o;
        int         sel;
        int         d;
        int         mid;
        logic [7:0] tt;

        gate_tt_a = TT_OR3;
        gate_tt_b = TT_AND3;
        do_reset();
        repeat (5) @(negedge clk);
        check("reset_outputs_a", 32'(sample(0)), 32'd0);
        check("reset_outputs_b", 32'(sample(1)), 32'd0);
        check("reset_state_a", 32'(st_a), 32'(IDLE));

        // Correct OR3, then stuck-at-0, then a start pulse inside pattern 2.
        run_seq(0, TT_OR3, -1, 1'b0);
        run_seq(0, 8'h00, -1, 1'b0);
        run_seq(0, TT_OR3, 9, 1'b0);

        // Reset while pattern 011 is on the pins.
        gate_tt_a = TT_OR3;
        set_start(0, 1'b1);
        @(negedge clk);
        set_start(0, 1'b0);
        repeat (12) @(negedge clk);
        o = sample(0);
        check("abc_before_rst", 32'(o.abc), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_run_outputs", 32'(sample(0)), 32'd0);
        check("rst_mid_run_state", 32'(st_a), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(0, TT_OR3, -1, 1'b0);

        // Dwell of one cycle with a correct AND3, then a faulty one.
        run_seq(1, TT_AND3, -1, 1'b0);
        run_seq(1, TT_NAND3, 3, 1'b0);

        // Start held high restarts straight out of DONE.
        run_seq(0, TT_XOR3, -1, 1'b1);
        do_reset();

        // Random gates and random mid-run start pulses.
        repeat (8) begin
            sel = int'($urandom_range(0, 1));
            d   = (sel != 0) ? DW_B : DW_A;
            if ($urandom_range(0, 3) == 0) tt = (sel != 0) ? TT_AND3 : TT_OR3;
            else                           tt = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) mid = -1;
            else                           mid = int'($urandom_range(0, 8 * d - 1));
            run_seq(sel, tt, mid, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
